// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Width for a counter that must hold 0..max; a disabled (0) limit still gets one bit.
  function automatic int cnt_width(input int max);
    return (max > 0) ? $clog2(max + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module arb_sat_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] TOP = W'(MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != TOP)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the I-fetch and D ports onto one variable-latency memory port,
// D first with a streak limit for I, and aborts accesses the memory never acks.
//
// state  | meaning
// IDLE   | no access outstanding, choosing the next port
// BUSY_I | fetch access presented to memory, waiting for mem_ack
// BUSY_D | load/store access presented to memory, waiting for mem_ack
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int SW = cnt_width(MAX_D_STREAK);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t    state;
  grant_t        grant;
  logic          grant_valid;
  logic          elig_i;
  logic          elig_d;
  logic          busy;
  logic          timeout_hit;
  logic          streak_clear;
  logic          streak_inc;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;

  // A port is not re-arbitrated in its own valid cycle, so a held request
  // that was just served is not mistaken for a new one.
  assign elig_i = i_req & ~i_valid;
  assign elig_d = d_req & ~d_valid;
  assign busy   = (state != IDLE);

  assign stall_if  = i_req & ~i_valid;
  assign stall_mem = d_req & ~d_valid;

  always_comb begin
    grant_valid = 1'b0;
    grant       = GRANT_D;
    if (state == IDLE) begin
      if (elig_d && (!elig_i || (streak != STREAK_MAX))) begin
        grant_valid = 1'b1;
      end else if (elig_i) begin
        grant_valid = 1'b1;
        grant       = GRANT_I;
      end
    end
  end

  assign streak_inc   = grant_valid && (grant == GRANT_D);
  assign streak_clear = !i_req || (grant_valid && (grant == GRANT_I));

  arb_sat_counter #(.MAX(MAX_D_STREAK), .W(SW)) u_streak (
    .clock (clock),
    .reset (reset),
    .clear (streak_clear),
    .inc   (streak_inc),
    .count (streak)
  );

  arb_sat_counter #(.MAX(TIMEOUT), .W(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (grant_valid),
    .inc   (busy && !mem_ack),
    .count (timer)
  );

  assign timeout_hit = (TIMEOUT > 0) && busy && !mem_ack && (timer == TIMER_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            mem_req <= 1'b1;
            if (grant == GRANT_D) begin
              state     <= BUSY_D;
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end else begin
              state    <= BUSY_I;
              mem_addr <= i_addr;
              mem_we   <= 1'b0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // An ack on the last allowed cycle still wins over the abort.
          if (mem_ack || timeout_hit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            err     <= !mem_ack;
            if (state == BUSY_I) begin
              i_valid <= 1'b1;
              i_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_valid <= 1'b1;
              if (!mem_ack) begin
                d_rdata <= '0;
              end else if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic for mem_port_arbiter, checked every
// cycle against a transaction-level model of the arbitration and handshake rules.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;
  localparam int TO   = 8;
  localparam logic [31:0] I_ADDR3 = 32'h0000_1000;
  localparam logic [31:0] D_ADDR3 = 32'h0000_2000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding access, decided on each rising edge.
  bit          m_busy = 0, m_port_d = 0, m_we = 0, m_to = 0;
  bit          exp_iv = 0, exp_dv = 0, exp_err = 0;
  bit          ei, ed, gi, gd;
  logic [31:0] m_addr = '0, m_wdata = '0, exp_irdata = '0, exp_drdata = '0, done_data;
  int          m_cnt = 0, streak = 0;

  always @(posedge clock) begin
    ei = i_req && !exp_iv;
    ed = d_req && !exp_dv;
    gi = 0;
    gd = 0;
    exp_iv = 0; exp_dv = 0; exp_err = 0;
    if (reset) begin
      m_busy = 0; m_we = 0; m_cnt = 0; streak = 0;
      m_addr = '0; m_wdata = '0; exp_irdata = '0; exp_drdata = '0;
    end else begin
      if (m_busy) begin
        m_to = 0;
        if (!mem_ack) begin
          m_cnt++;
          m_to = (m_cnt >= TO);
        end
        if (mem_ack || m_to) begin
          done_data = m_to ? 32'h0 : mem_rdata;
          m_busy = 0;
          exp_err = m_to;
          if (m_port_d) begin
            exp_dv = 1;
            if (m_to || !m_we) exp_drdata = done_data;
          end else begin
            exp_iv = 1;
            exp_irdata = done_data;
          end
        end
      end else begin
        gd = ed && (!ei || streak < MAXS);
        gi = ei && !gd;
        if (gd) begin
          m_busy = 1; m_port_d = 1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_cnt = 0;
        end else if (gi) begin
          m_busy = 1; m_port_d = 0; m_addr = i_addr; m_we = 0; m_cnt = 0;
        end
      end
      if (gd && i_req) streak = (streak < MAXS) ? streak + 1 : streak;
      else if (gi || !i_req) streak = 0;
    end
  end

  // Environment state, all driven from the single stimulus process below.
  bit          chk_en = 0, auto_req = 0, auto_mem = 0, spurious = 0, hold_i = 0, hold_d = 0;
  bit          prev_mreq = 0;
  int          lat_max = 0, lat_cnt = 0, cyc = 0, iv_cyc = -1, dv_cyc = -1;
  logic [31:0] glog[$];
  int          gcyc[$];

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (chk_en) begin
      check("mem_req",   32'(mem_req), 32'(m_busy));
      check("mem_addr",  mem_addr, m_addr);
      check("mem_we",    32'(mem_we), 32'(m_we));
      check("mem_wdata", mem_wdata, m_wdata);
      check("i_valid",   32'(i_valid), 32'(exp_iv));
      check("d_valid",   32'(d_valid), 32'(exp_dv));
      check("err",       32'(err), 32'(exp_err));
      check("i_rdata",   i_rdata, exp_irdata);
      check("d_rdata",   d_rdata, exp_drdata);
      check("stall_if",  32'(stall_if), 32'(i_req & ~exp_iv));
      check("stall_mem", 32'(stall_mem), 32'(d_req & ~exp_dv));
    end
    if (mem_req && !prev_mreq) begin
      glog.push_back(mem_addr);
      gcyc.push_back(cyc);
    end
    prev_mreq = mem_req;
    if (i_valid) iv_cyc = cyc;
    if (d_valid) dv_cyc = cyc;
    #1;
    if (auto_req) begin
      if (i_req) begin
        if (i_valid) begin
          if ($urandom_range(0, 1) == 1) i_addr = $urandom & 32'h0000_FFFC;
          else i_req = 0;
        end else if ($urandom_range(0, 31) == 0) i_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom & 32'h0000_FFFC;
      end
      if (d_req) begin
        if (d_valid) begin
          if ($urandom_range(0, 1) == 1) begin
            d_addr = $urandom & 32'h0001_FFFC; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
          end else d_req = 0;
        end else if ($urandom_range(0, 31) == 0) d_req = 0;
      end else if ($urandom_range(0, 1) == 0) begin
        d_req = 1; d_addr = $urandom & 32'h0001_FFFC; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
    end else begin
      if (i_valid && !hold_i) i_req = 0;
      if (d_valid && !hold_d) d_req = 0;
    end
    if (auto_mem) begin
      if (mem_req) begin
        if (lat_cnt == 0) begin
          mem_ack = 1; mem_rdata = $urandom;
        end else begin
          mem_ack = 0; lat_cnt--;
        end
      end else begin
        mem_ack = spurious && ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
        lat_cnt = $urandom_range(0, lat_max);
      end
    end
  endtask

  int  busy_cnt;
  bit  seen;

  initial begin
    repeat (3) tick();
    reset = 0;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_valids", {30'd0, i_valid, d_valid}, 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    check("rst_err", 32'(err), 0);
    chk_en = 1;
    tick();

    // Lone load, memory answers on the fourth busy cycle.
    d_req = 1; d_we = 0; d_addr = 32'h40;
    tick();
    check("t1_mem_req", 32'(mem_req), 1);
    check("t1_mem_addr", mem_addr, 32'h40);
    check("t1_stall_mem", 32'(stall_mem), 1);
    repeat (3) begin
      tick();
      check("t1_held", 32'(mem_req), 1);
    end
    mem_ack = 1; mem_rdata = 32'h1234;
    tick();
    check("t1_d_valid", 32'(d_valid), 1);
    check("t1_d_rdata", d_rdata, 32'h1234);
    mem_ack = 0;
    tick();
    check("t1_d_valid_pulse", 32'(d_valid), 0);
    check("t1_stall_after", 32'(stall_mem), 0);

    // Store leaves d_rdata alone even though the memory drives read data.
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hCAFE_F00D;
    tick();
    check("t4_mem_we", 32'(mem_we), 1);
    check("t4_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("t4_d_valid", 32'(d_valid), 1);
    check("t4_d_rdata", d_rdata, 32'h1234);
    mem_ack = 0; d_we = 0;
    tick();
    check("t4_d_valid_pulse", 32'(d_valid), 0);

    // Simultaneous requests with zero-latency memory.
    auto_mem = 1; lat_max = 0; spurious = 0;
    tick();
    glog.delete(); gcyc.delete(); iv_cyc = -1; dv_cyc = -1;
    i_req = 1; i_addr = I_ADDR3; d_req = 1; d_addr = D_ADDR3;
    for (int n = 0; n < 20 && iv_cyc < 0; n++) tick();
    check("t2_first_grant", (glog.size() > 0) ? glog[0] : 32'hFFFF_FFFF, D_ADDR3);
    check("t2_d_seen", 32'(dv_cyc >= 0), 1);
    check("t2_i_after_d", iv_cyc - dv_cyc, 2);
    repeat (3) tick();

    // Both requests held: D is not eligible in its own valid cycle, so service alternates.
    glog.delete(); gcyc.delete();
    hold_i = 1; hold_d = 1;
    i_req = 1; i_addr = I_ADDR3; d_req = 1; d_addr = D_ADDR3;
    repeat (16) tick();
    hold_i = 0; hold_d = 0; i_req = 0; d_req = 0;
    check("t3_grant_count", 32'(glog.size() >= 6), 1);
    for (int n = 0; n < 6 && n < glog.size(); n++) begin
      check($sformatf("t3_grant%0d", n), glog[n], (n % 2 == 0) ? D_ADDR3 : I_ADDR3);
      if (n > 0) check($sformatf("t3_spacing%0d", n), gcyc[n] - gcyc[n-1], 2);
    end
    repeat (4) tick();

    // Hung memory: fetch aborts after TO busy cycles.
    auto_mem = 0; mem_ack = 0;
    tick();
    i_req = 1; i_addr = 32'h300;
    busy_cnt = 0; seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      tick();
      if (err) begin
        seen = 1;
        check("t5_i_valid", 32'(i_valid), 1);
        check("t5_i_rdata", i_rdata, 0);
        check("t5_mem_req", 32'(mem_req), 0);
      end else if (mem_req) busy_cnt++;
    end
    check("t5_err_seen", 32'(seen), 1);
    check("t5_busy_cycles", busy_cnt, TO);
    tick();
    check("t5_err_pulse", 32'(err), 0);

    // Reset during the second busy cycle, then a late ack.
    d_req = 1; d_we = 0; d_addr = 32'h44;
    tick();
    tick();
    reset = 1; d_req = 0;
    tick();
    check("t6_mem_req_rst", 32'(mem_req), 0);
    reset = 0; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    repeat (3) begin
      tick();
      check("t6_idle", 32'(mem_req), 0);
      check("t6_no_valid", {30'd0, i_valid, d_valid}, 0);
    end
    mem_ack = 0;
    tick();

    // Randomized traffic, including drops, spurious acks and timeouts.
    auto_mem = 1; lat_max = 10; spurious = 1; auto_req = 1;
    repeat (3000) tick();
    auto_req = 0; spurious = 0; lat_max = 3;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      seen = !i_req && !d_req && !mem_req;
    end
    check("drain", 32'(seen), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
